weight_seq_mux: RTL

Parametrised successor to the fixed 28-way registered weight multiplexer. Selects one WIDTH-bit weight from NUM_IN packed inputs and presents it registered on a valid/ready output stream. It has two modes:
- Manual: host-indexed selection.
- Auto: an internal sequencer walks a programmable index window, with wrap-around and optional looping.

It sits between the weight register bank and the MAC datapath and replaces per-cycle select generation in the controller.

---
 rtl/weight_mux_pkg.sv | 15 +
 rtl/weight_slice_sel.sv | 25 ++
 rtl/weight_seq_mux.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/weight_mux_pkg.sv
// Shared types and elaboration helpers for the sequenced weight multiplexer.
package weight_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  // True when SEL_W can address every input and NUM_IN is in the supported range.
  function automatic bit params_ok(input int num_in, input int sel_w);
    return (num_in >= 2) && (num_in <= 64) && ((64'd1 << sel_w) >= 64'(num_in));
  endfunction

endpackage

// File: rtl/weight_slice_sel.sv
// Combinational NUM_IN:1 weight selector; out-of-range indices return slice 0.
module weight_slice_sel #(
  parameter int WIDTH  = 19,
  parameter int NUM_IN = 28,
  parameter int SEL_W  = 6
) (
  input  logic [NUM_IN*WIDTH-1:0] wt_bus,
  input  logic [SEL_W-1:0]        idx,
  output logic [WIDTH-1:0]        data,
  output logic                    oob
);

  // NOTE: both outputs get a default before the loop so no path leaves them unassigned (no latch).
  always_comb begin
    data = wt_bus[WIDTH-1:0];
    oob  = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (idx == SEL_W'(i)) begin
        data = wt_bus[i*WIDTH +: WIDTH];
        oob  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/weight_seq_mux.sv
// Registered weight multiplexer with manual indexing and an auto window sequencer on a valid/ready output.
module weight_seq_mux
  import weight_mux_pkg::*;
#(
  parameter int WIDTH  = 19,
  parameter int NUM_IN = 28,
  parameter int SEL_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] wt_bus,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic                    sel_valid,
  input  logic                    start,
  input  logic [SEL_W-1:0]        base_idx,
  input  logic [SEL_W:0]          count,
  input  logic                    loop,
  input  logic                    stop,
  output logic [WIDTH-1:0]        wt_out,
  output logic [SEL_W-1:0]        wt_idx,
  output logic                    wt_valid,
  input  logic                    wt_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    sel_err
);

  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_IN - 1);
  localparam logic [SEL_W:0]   REM_ONE  = (SEL_W + 1)'(1);

  if (!params_ok(NUM_IN, SEL_W)) begin : g_param_err
    $error("weight_seq_mux: NUM_IN must be 2..64 and fit in SEL_W bits");
  end

  seq_state_e       state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [SEL_W:0]   rem_q, rem_d;
  logic             loop_q, loop_d;
  logic [WIDTH-1:0] wt_out_q, wt_out_d;
  logic [SEL_W-1:0] wt_idx_q, wt_idx_d;
  logic             wt_valid_q, wt_valid_d;
  logic             sel_err_q, sel_err_d;
  logic             done_q, done_d;

  logic             load;
  logic             issue;
  logic [SEL_W-1:0] issue_idx;
  logic [WIDTH-1:0] sel_data;
  logic             sel_oob;

  weight_slice_sel #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN),
    .SEL_W (SEL_W)
  ) u_slice_sel (
    .wt_bus(wt_bus),
    .idx   (issue_idx),
    .data  (sel_data),
    .oob   (sel_oob)
  );

  assign load = !wt_valid_q || wt_ready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rem_d      = rem_q;
    loop_d     = loop_q;
    issue      = 1'b0;
    issue_idx  = idx_q;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && (count != '0)) begin
          state_d = ST_RUN;
          idx_d   = base_idx;
          rem_d   = count;
          loop_d  = loop;
        end else if (sel_valid && load) begin
          issue     = 1'b1;
          issue_idx = sel_in;
        end
      end
      ST_RUN: begin
        if (load) begin
          issue = 1'b1;
          idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          rem_d = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            if (loop_q && (count != '0)) begin
              idx_d = base_idx;
              rem_d = count;
            end else begin
              state_d = ST_DRAIN;
            end
          end
        end
        // Abort wins over both continuing and draining; a word issued this cycle is still delivered.
        if (stop) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (load) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wt_out_d   = wt_out_q;
    wt_idx_d   = wt_idx_q;
    wt_valid_d = wt_valid_q && !wt_ready;
    sel_err_d  = 1'b0;
    if (issue) begin
      wt_out_d   = sel_data;
      wt_idx_d   = issue_idx;
      wt_valid_d = 1'b1;
      sel_err_d  = sel_oob;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      rem_q      <= '0;
      loop_q     <= 1'b0;
      wt_out_q   <= '0;
      wt_idx_q   <= '0;
      wt_valid_q <= 1'b0;
      sel_err_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rem_q      <= rem_d;
      loop_q     <= loop_d;
      wt_out_q   <= wt_out_d;
      wt_idx_q   <= wt_idx_d;
      wt_valid_q <= wt_valid_d;
      sel_err_q  <= sel_err_d;
      done_q     <= done_d;
    end
  end

  assign wt_out   = wt_out_q;
  assign wt_idx   = wt_idx_q;
  assign wt_valid = wt_valid_q;
  assign sel_err  = sel_err_q;
  assign done     = done_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
